control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Fetch/execute sequencer that drives instruction_register.load (ld_ir) and consumes its d_out[7:5] as opcode.
//  Steps an 8-phase instruction cycle and emits memory, PC, accumulator and IR strobes.
//  Sits between instruction_register and the datapath (PC, ACC, ALU, memory bus).
// PARAMETERS
//  WORD_SIZE   8   instruction width; opcode = instruction[WORD_SIZE-1 -: OPC_WIDTH]
//  OPC_WIDTH   3   opcode width
//  TIMEOUT     15  max consecutive mem_ready-low cycles in a wait phase before bus error
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous reset, active-low
//  opcode     in   3  from instruction_register d_out[7:5]
//  zero       in   1  accumulator-zero flag
//  mem_ready  in   1  memory read data valid this cycle
//  run        in   1  one-cycle pulse; restarts from HALTED
//  sel        out  1  1 = address bus from PC, 0 = from IR operand
//  rd / wr    out  1  memory read / write strobe
//  ld_ir      out  1  load strobe to instruction_register
//  ld_ac      out  1  accumulator load
//  ld_pc      out  1  PC parallel load (jump)
//  inc_pc     out  1  PC increment
//  data_e     out  1  drive ACC onto data bus
//  halted     out  1  sequencer stopped
//  bus_err    out  1  sticky; set on memory timeout
//  phase      out  3  current phase P0..P7
// BEHAVIOUR
//  Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP; ALUOP = ADD|AND|XOR|LDA.
//  Registered state: phase[2:0], halted, bus_err, wait_cnt[3:0]. All outputs decode from this state plus opcode and zero.
//  On rst low, immediately and at any point mid-cycle: phase=P0, halted=0, bus_err=0, wait_cnt=0.
//    Resulting outputs: sel=1, all other strobes 0.
//  Phase outputs (unlisted = 0):
//   P0 INST_ADDR : sel
//   P1 INST_FETCH: sel, rd
//   P2 INST_LOAD : sel, rd, ld_ir
//   P3 IDLE      : sel, rd, ld_ir
//   P4 OP_ADDR   : inc_pc; halt condition evaluated for HLT
//   P5 OP_FETCH  : rd if ALUOP
//   P6 ALU_OP    : rd if ALUOP; inc_pc if SKZ&&zero; ld_pc if JMP; data_e if STO
//   P7 STORE     : rd, ld_ac if ALUOP; ld_pc if JMP; wr, data_e if STO
//  Advance: phase += 1 each clk, with P7 wrapping to P0.
//  Wait states, P1 always and P5 only when ALUOP:
//   - Hold while mem_ready=0 and increment wait_cnt.
//   - Advance on mem_ready=1 and clear wait_cnt.
//   - When wait_cnt reaches TIMEOUT with mem_ready still 0: set bus_err and halted, phase=P0.
//  HLT: at the end of P4 with opcode=0, set halted=1 and phase=P0.
//  While halted:
//   - All strobes are 0 and sel=1; phase holds.
//   - run=1 clears halted, and fetch resumes at P0 on the next clk.
//   - run has no effect if bus_err=1; only rst clears bus_err.
//  run while not halted: ignored.
//  Nominal instruction latency: 8 clk plus wait cycles. ld_ir is high exactly in P2 and P3.
//  opcode is sampled combinationally and is valid from P4 onward, because the IR loads at the end of P2/P3.
// TESTING
//  1. Reset: rst=0 mid-P6 -> phase=0, sel=1, rd=wr=ld_*=inc_pc=0, halted=0, bus_err=0 immediately.
//  2. LDA (opcode=5), mem_ready=1:
//     - P1..P3 rd=1; P2,P3 ld_ir=1.
//     - P4 inc_pc=1; P7 ld_ac=1.
//     - Back to P0 after 8 clk.
//  3. SKZ (opcode=1): zero=1 -> inc_pc=1 in P4 and P6. zero=0 -> inc_pc only in P4.
//  4. STO (6) -> data_e in P6,P7; wr=1 only in P7. JMP (7) -> ld_pc in P6,P7.
//  5. mem_ready=0 for 3 clk in P1 -> phase stays 1 for 3 clk, then advances.
//     mem_ready=0 for 15 clk -> bus_err=1, halted=1; run pulse ignored.
//  6. HLT (0) -> halted=1 after P4, strobes quiet for 10 clk. run pulse -> P0, fetch resumes.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// control_sequencer : 8-phase fetch/execute sequencer with memory wait states,
//                     HLT/run handling and sticky bus-error timeout.
// Revision 1.0
// ============================================================================
module control_sequencer #(
    parameter int WORD_SIZE = 8,
    parameter int OPC_WIDTH = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    input  logic                 run,
    output logic                 sel,
    output logic                 rd,
    output logic                 wr,
    output logic                 ld_ir,
    output logic                 ld_ac,
    output logic                 ld_pc,
    output logic                 inc_pc,
    output logic                 data_e,
    output logic                 halted,
    output logic                 bus_err,
    output logic [2:0]           phase
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] C_WAIT_LAST = WCW'(TIMEOUT - 1);

    localparam logic [OPC_WIDTH-1:0] C_OP_HLT = OPC_WIDTH'(0);
    localparam logic [OPC_WIDTH-1:0] C_OP_SKZ = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] C_OP_ADD = OPC_WIDTH'(2);
    localparam logic [OPC_WIDTH-1:0] C_OP_AND = OPC_WIDTH'(3);
    localparam logic [OPC_WIDTH-1:0] C_OP_XOR = OPC_WIDTH'(4);
    localparam logic [OPC_WIDTH-1:0] C_OP_LDA = OPC_WIDTH'(5);
    localparam logic [OPC_WIDTH-1:0] C_OP_STO = OPC_WIDTH'(6);
    localparam logic [OPC_WIDTH-1:0] C_OP_JMP = OPC_WIDTH'(7);

    // The opcode field must fit inside the instruction word.
    if (OPC_WIDTH > WORD_SIZE) begin : g_width_guard
        $error("OPC_WIDTH exceeds WORD_SIZE");
    end

    typedef enum logic [2:0] {
        P0_INST_ADDR  = 3'd0,
        P1_INST_FETCH = 3'd1,
        P2_INST_LOAD  = 3'd2,
        P3_IDLE       = 3'd3,
        P4_OP_ADDR    = 3'd4,
        P5_OP_FETCH   = 3'd5,
        P6_ALU_OP     = 3'd6,
        P7_STORE      = 3'd7
    } phase_e;

    phase_e         phase_q, phase_d;
    logic           halted_q, halted_d;
    logic           bus_err_q, bus_err_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

    logic w_alu_op;
    logic w_is_skz;
    logic w_is_sto;
    logic w_is_jmp;
    logic w_wait_phase;

    assign w_alu_op = (opcode == C_OP_ADD) || (opcode == C_OP_AND) ||
                      (opcode == C_OP_XOR) || (opcode == C_OP_LDA);
    assign w_is_skz = (opcode == C_OP_SKZ);
    assign w_is_sto = (opcode == C_OP_STO);
    assign w_is_jmp = (opcode == C_OP_JMP);
    assign w_wait_phase = (phase_q == P1_INST_FETCH) ||
                          ((phase_q == P5_OP_FETCH) && w_alu_op);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q    <= P0_INST_ADDR;
            halted_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            halted_q   <= halted_d;
            bus_err_q  <= bus_err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        halted_d   = halted_q;
        bus_err_d  = bus_err_q;
        wait_cnt_d = '0;
        if (halted_q) begin
            // A bus error can only be cleared by reset, so it blocks restart.
            if (run && !bus_err_q) begin
                halted_d = 1'b0;
            end
        end else if (w_wait_phase && !mem_ready) begin
            if (wait_cnt_q == C_WAIT_LAST) begin
                bus_err_d = 1'b1;
                halted_d  = 1'b1;
                phase_d   = P0_INST_ADDR;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end else if ((phase_q == P4_OP_ADDR) && (opcode == C_OP_HLT)) begin
            halted_d = 1'b1;
            phase_d  = P0_INST_ADDR;
        end else begin
            phase_d = phase_e'(3'(phase_q + 3'd1));
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        if (halted_q) begin
            sel = 1'b1;
        end else begin
            case (phase_q)
                P0_INST_ADDR: begin
                    sel = 1'b1;
                end
                P1_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                P2_INST_LOAD, P3_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                P4_OP_ADDR: begin
                    inc_pc = 1'b1;
                end
                P5_OP_FETCH: begin
                    rd = w_alu_op;
                end
                P6_ALU_OP: begin
                    rd     = w_alu_op;
                    inc_pc = w_is_skz && zero;
                    ld_pc  = w_is_jmp;
                    data_e = w_is_sto;
                end
                P7_STORE: begin
                    rd     = w_alu_op;
                    ld_ac  = w_alu_op;
                    ld_pc  = w_is_jmp;
                    wr     = w_is_sto;
                    data_e = w_is_sto;
                end
                default: begin
                    sel = 1'b1;
                end
            endcase
        end
    end

    assign halted  = halted_q;
    assign bus_err = bus_err_q;
    assign phase   = phase_q;

endmodule
`default_nettype wire
